// File: rtl/fib_seq_gen.sv
// Fibonacci-sequence stream source with programmable seeds and term count.
// Emits terms over valid/ready with a last marker, done pulse and sticky overflow.
module fib_seq_gen #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned CNT_W    = 16,
  parameter int unsigned SATURATE = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start_i,
  input  logic [WIDTH-1:0] seed0_i,
  input  logic [WIDTH-1:0] seed1_i,
  input  logic [CNT_W-1:0] num_terms_i,
  input  logic             ready_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] seq_o,
  output logic             last_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             ovf_o
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] w_a_nxt;
  logic [WIDTH-1:0] w_b_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_n;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [CNT_W-1:0] w_n_nxt;
  logic             r_done;
  logic             w_done_nxt;
  logic             r_ovf;
  logic             w_ovf_nxt;
  logic [WIDTH:0]   w_sum_full;
  logic [WIDTH-1:0] w_sum;
  logic             w_run;
  logic             w_last;
  logic             w_fire;

  // Carry-extended sum; clamp to all-ones only in saturating builds
  assign w_sum_full = {1'b0, r_a} + {1'b0, r_b};
  assign w_sum      = ((SATURATE != 0) && w_sum_full[WIDTH]) ? '1 : w_sum_full[WIDTH-1:0];

  assign w_run  = (r_state == S_RUN);
  assign w_last = w_run && (r_cnt == (r_n - CNT_W'(1)));
  assign w_fire = w_run && ready_i;

  // Next-state and datapath update
  always_comb begin
    w_state_nxt = r_state;
    w_a_nxt     = r_a;
    w_b_nxt     = r_b;
    w_cnt_nxt   = r_cnt;
    w_n_nxt     = r_n;
    w_ovf_nxt   = r_ovf;
    w_done_nxt  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start_i && (num_terms_i != '0)) begin
          w_state_nxt = S_RUN;
          w_a_nxt     = seed0_i;
          w_b_nxt     = seed1_i;
          w_cnt_nxt   = '0;
          w_n_nxt     = num_terms_i;
          w_ovf_nxt   = 1'b0;
        end
      end
      S_RUN: begin
        if (w_fire) begin
          if (w_last) begin
            w_state_nxt = S_IDLE;
            w_done_nxt  = 1'b1;
          end else begin
            w_a_nxt   = r_b;
            w_b_nxt   = w_sum;
            w_cnt_nxt = r_cnt + CNT_W'(1);
            if (w_sum_full[WIDTH]) begin
              w_ovf_nxt = 1'b1;
            end
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_cnt   <= '0;
      r_n     <= '0;
      r_done  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_a     <= w_a_nxt;
      r_b     <= w_b_nxt;
      r_cnt   <= w_cnt_nxt;
      r_n     <= w_n_nxt;
      r_done  <= w_done_nxt;
      r_ovf   <= w_ovf_nxt;
    end
  end

  // Outputs depend on registers only, never on ready_i
  assign valid_o = w_run;
  assign busy_o  = w_run;
  assign seq_o   = r_a;
  assign last_o  = w_last;
  assign done_o  = r_done;
  assign ovf_o   = r_ovf;

endmodule

// File: tb/tb_fib_seq_gen.sv
// Randomized bench for fib_seq_gen: three instances (32-bit wrap, 8-bit wrap,
// 8-bit saturate) run in lockstep against a term-list reference model.
module tb_fib_seq_gen;

  logic        clk;
  logic        reset_n;
  logic        start_i;
  logic [31:0] seed0_i;
  logic [31:0] seed1_i;
  logic [15:0] num_terms_i;
  logic        ready_i;

  logic [2:0]  v_o;
  logic [2:0]  l_o;
  logic [2:0]  b_o;
  logic [2:0]  d_o;
  logic [2:0]  o_o;
  logic [31:0] q32;
  logic [7:0]  q8w;
  logic [7:0]  q8s;

  int n_checks = 0;
  int n_fail   = 0;

  // Expected terms per instance; m_ov[d][k] marks that producing term k overflowed
  longint unsigned m_t[3][64];
  bit              m_ov[3][64];
  longint unsigned prev_seq[3];
  bit              prev_ovf[3];

  fib_seq_gen #(.WIDTH(32), .CNT_W(16), .SATURATE(0)) u_w32 (
    .clk(clk), .reset_n(reset_n), .start_i(start_i),
    .seed0_i(seed0_i), .seed1_i(seed1_i), .num_terms_i(num_terms_i),
    .ready_i(ready_i), .valid_o(v_o[0]), .seq_o(q32), .last_o(l_o[0]),
    .busy_o(b_o[0]), .done_o(d_o[0]), .ovf_o(o_o[0])
  );

  fib_seq_gen #(.WIDTH(8), .CNT_W(16), .SATURATE(0)) u_w8 (
    .clk(clk), .reset_n(reset_n), .start_i(start_i),
    .seed0_i(seed0_i[7:0]), .seed1_i(seed1_i[7:0]), .num_terms_i(num_terms_i),
    .ready_i(ready_i), .valid_o(v_o[1]), .seq_o(q8w), .last_o(l_o[1]),
    .busy_o(b_o[1]), .done_o(d_o[1]), .ovf_o(o_o[1])
  );

  fib_seq_gen #(.WIDTH(8), .CNT_W(16), .SATURATE(1)) u_s8 (
    .clk(clk), .reset_n(reset_n), .start_i(start_i),
    .seed0_i(seed0_i[7:0]), .seed1_i(seed1_i[7:0]), .num_terms_i(num_terms_i),
    .ready_i(ready_i), .valid_o(v_o[2]), .seq_o(q8s), .last_o(l_o[2]),
    .busy_o(b_o[2]), .done_o(d_o[2]), .ovf_o(o_o[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint unsigned obs, input longint unsigned exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  function automatic longint unsigned seq_of(input int d);
    case (d)
      0:       return 64'(q32);
      1:       return 64'(q8w);
      default: return 64'(q8s);
    endcase
  endfunction

  // Fibonacci term list per instance from plain arithmetic on 64-bit values
  function automatic void build_model(input longint unsigned s0, input longint unsigned s1,
                                      input int n);
    for (int d = 0; d < 3; d++) begin
      longint unsigned mask;
      longint unsigned raw;
      mask = (d == 0) ? 64'hFFFF_FFFF : 64'hFF;
      m_t[d][0]  = s0 & mask;
      m_t[d][1]  = s1 & mask;
      m_ov[d][0] = 1'b0;
      m_ov[d][1] = 1'b0;
      for (int k = 2; k <= n; k++) begin
        raw        = m_t[d][k-1] + m_t[d][k-2];
        m_ov[d][k] = (raw > mask);
        if (raw > mask) m_t[d][k] = (d == 2) ? mask : (raw & mask);
        else            m_t[d][k] = raw;
      end
    end
  endfunction

  // Overflow seen by the sums performed by fires of terms 0..i-1
  function automatic bit ovf_upto(input int d, input int i);
    bit r;
    r = 1'b0;
    for (int k = 2; k <= i + 1; k++) r |= m_ov[d][k];
    return r;
  endfunction

  task automatic check_term(input int idx, input int n);
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("d%0d_t%0d_valid", d, idx), 64'(v_o[d]), 1);
      chk($sformatf("d%0d_t%0d_seq", d, idx), seq_of(d), m_t[d][idx]);
      chk($sformatf("d%0d_t%0d_last", d, idx), 64'(l_o[d]), 64'(idx == n - 1));
      chk($sformatf("d%0d_t%0d_busy", d, idx), 64'(b_o[d]), 1);
      chk($sformatf("d%0d_t%0d_done", d, idx), 64'(d_o[d]), 0);
      chk($sformatf("d%0d_t%0d_ovf", d, idx), 64'(o_o[d]), 64'(ovf_upto(d, idx)));
    end
  endtask

  task automatic check_idle(input string tag, input bit exp_done);
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("%s_d%0d_valid", tag, d), 64'(v_o[d]), 0);
      chk($sformatf("%s_d%0d_busy", tag, d), 64'(b_o[d]), 0);
      chk($sformatf("%s_d%0d_last", tag, d), 64'(l_o[d]), 0);
      chk($sformatf("%s_d%0d_done", tag, d), 64'(d_o[d]), 64'(exp_done));
      chk($sformatf("%s_d%0d_ovf", tag, d), 64'(o_o[d]), 64'(prev_ovf[d]));
      chk($sformatf("%s_d%0d_seq", tag, d), seq_of(d), prev_seq[d]);
    end
  endtask

  // mode 0: ready always 1; 1: random ready plus stray starts; 2: ready pattern 1,0,0
  task automatic run(input logic [31:0] s0, input logic [31:0] s1, input int n, input int mode);
    int idx;
    int cyc;
    bit rdy;
    build_model(64'(s0), 64'(s1), n);
    start_i     = 1'b1;
    seed0_i     = s0;
    seed1_i     = s1;
    num_terms_i = 16'(n);
    ready_i     = 1'b0;
    @(negedge clk);
    start_i = 1'b0;
    idx = 0;
    cyc = 0;
    while (idx < n && cyc < 2000) begin
      check_term(idx, n);
      case (mode)
        0:       rdy = 1'b1;
        2:       rdy = ((cyc % 3) == 0);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      ready_i     = rdy;
      start_i     = (mode == 1) && ($urandom_range(0, 5) == 0);
      seed0_i     = $urandom;
      seed1_i     = $urandom;
      num_terms_i = 16'($urandom_range(0, 50));
      @(negedge clk);
      cyc++;
      if (rdy) idx++;
    end
    start_i = 1'b0;
    ready_i = 1'b0;
    chk("run_accept_count", 64'(idx), 64'(n));
    for (int d = 0; d < 3; d++) begin
      prev_seq[d] = m_t[d][n-1];
      prev_ovf[d] = ovf_upto(d, n - 1);
    end
    check_idle("end", 1'b1);
    @(negedge clk);
    check_idle("post", 1'b0);
  endtask

  initial begin
    int idx;
    reset_n     = 1'b0;
    start_i     = 1'b0;
    seed0_i     = '0;
    seed1_i     = '0;
    num_terms_i = '0;
    ready_i     = 1'b0;
    for (int d = 0; d < 3; d++) begin
      prev_seq[d] = 0;
      prev_ovf[d] = 1'b0;
    end
    repeat (3) @(negedge clk);
    check_idle("reset", 1'b0);
    reset_n = 1'b1;
    @(negedge clk);

    run(32'd0, 32'd1, 10, 0);
    run(32'd2, 32'd1, 6, 2);
    run(32'd0, 32'd1, 15, 0);
    chk("wrap_last", 64'(q8w), 121);
    chk("sat_last", 64'(q8s), 255);

    // Zero-length start is ignored and leaves the sticky flag alone
    start_i     = 1'b1;
    num_terms_i = '0;
    @(negedge clk);
    start_i = 1'b0;
    repeat (3) begin
      check_idle("n0", 1'b0);
      @(negedge clk);
    end

    run(32'd7, 32'd9, 1, 1);
    run(32'hFFFF_FFF0, 32'h0000_0020, 5, 0);

    for (int r = 0; r < 14; r++) begin
      run($urandom, $urandom, int'($urandom_range(1, 40)), 1);
    end

    // Mid-run reset aborts asynchronously
    build_model(64'd0, 64'd1, 20);
    start_i     = 1'b1;
    seed0_i     = 32'd0;
    seed1_i     = 32'd1;
    num_terms_i = 16'd20;
    @(negedge clk);
    start_i = 1'b0;
    ready_i = 1'b1;
    for (idx = 0; idx < 5; idx++) begin
      check_term(idx, 20);
      @(negedge clk);
    end
    reset_n = 1'b0;
    #1;
    for (int d = 0; d < 3; d++) begin
      prev_seq[d] = 0;
      prev_ovf[d] = 1'b0;
    end
    check_idle("async_rst", 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check_idle("after_rst", 1'b0);
    end
    ready_i = 1'b0;
    run(32'd0, 32'd1, 8, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fib_seq_gen.md
Name: fib_seq_gen

Overview:
- Parametrised Fibonacci-sequence source with run control, programmable seeds and term count.
- Emits terms over a valid/ready stream with a last-term marker.
- Optional saturating arithmetic and a sticky overflow flag.
- Used as a configurable test-pattern and stimulus source feeding downstream datapath blocks.

Parameters:
- WIDTH, 32, bit width of seeds and sequence terms.
- CNT_W, 16, bit width of the term counter and num_terms.
- SATURATE, 0, 0 = modulo-2^WIDTH wrap on overflow; 1 = clamp sums at all-ones.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous active-low reset.
- start_i  input  1  begin a run; sampled only in IDLE.
- seed0_i  input  WIDTH  first term of the run.
- seed1_i  input  WIDTH  second term of the run.
- num_terms_i  input  CNT_W  number of terms to emit; sampled with start_i.
- ready_i  input  1  downstream accepts the current term.
- valid_o  output  1  seq_o holds a valid term.
- seq_o  output  WIDTH  current term.
- last_o  output  1  current term is the final term of the run.
- busy_o  output  1  run in progress (state RUN).
- done_o  output  1  one-cycle pulse after the last term is accepted.
- ovf_o  output  1  sticky overflow flag for the current/previous run.

Behaviour:
- Reset (reset_n low, async): state IDLE. valid_o, seq_o, last_o, busy_o, done_o, ovf_o all 0. Internal registers a, b and cnt are 0.
- States: IDLE, RUN.
- IDLE -> RUN on start_i=1 with num_terms_i!=0. Load a=seed0_i, b=seed1_i, cnt=0, latch N=num_terms_i, clear ovf_o.
  - Next cycle: valid_o=1, seq_o=seed0_i. Latency from start to first valid is 1 cycle.
- start_i with num_terms_i=0: ignored; stay IDLE, no done_o pulse.
- start_i in RUN: ignored.
- seq_o is always register a. valid_o = (state==RUN). last_o = valid_o && (cnt==N-1).
- fire = valid_o && ready_i.
  - While !fire: a, b, cnt and seq_o are held stable. Sampling ready_i must not change any output combinationally.
- On fire, not last: a<=b, b<=sum, cnt<=cnt+1.
  - sum = a+b as a WIDTH+1-bit result.
  - If the carry bit is set: ovf_o<=1. If SATURATE=1, sum is clamped to all-ones; otherwise it is truncated to WIDTH bits.
- On fire, last: state<=IDLE, valid_o<=0, done_o<=1 for exactly one cycle. No sum is computed and ovf_o is not updated.
- ovf_o: sticky until the next accepted start. It stays visible in IDLE after the run.
- Saturation persists: once a term is all-ones, every later sum is clamped to all-ones.
- N=1: emits seed0 only, with last_o=1 on that term.
- Max N = 2^CNT_W-1. cnt never wraps because the run ends at N-1.
- In IDLE, seq_o retains the last emitted term. Only values with valid_o=1 are meaningful.
- reset_n asserted mid-run aborts immediately to the reset values. The run does not resume after reset release.
- Arithmetic is unsigned throughout.

Test Plan:
- Basic run: WIDTH=32, seeds 0/1, N=10, ready_i=1 -> terms 0,1,1,2,3,5,8,13,21,34 on 10 consecutive cycles starting one cycle after start. last_o with 34. done_o one cycle later. busy_o low after. ovf_o=0.
- Backpressure: seeds 2/1, N=6, ready_i toggling 1,0,0,1,... -> accepted sequence 2,1,3,4,7,11. seq_o stable during every ready_i=0 cycle. Term count is exact. last_o only on 11.
- Overflow wrap: WIDTH=8, SATURATE=0, seeds 0/1, N=15 -> last two terms 233, 121 (377 mod 256). ovf_o sets on the fire of term 144 and stays 1 after done_o.
- Saturate: same as the overflow-wrap case with SATURATE=1 -> last two terms 233, 255. ovf_o=1. A following start clears ovf_o.
- Edge counts: N=0 with start -> no valid_o, no done_o, busy_o=0. N=1 seeds 7/9 -> single term 7 with last_o=1, then done_o. start_i pulsed during RUN -> no effect on the ongoing sequence.
- Mid-run reset: seeds 0/1, N=20, assert reset_n low after 5 accepts -> all outputs 0 asynchronously. After release, with no start, valid_o stays 0. A new start restarts from seed0.
